// File: rtl/div_pipe_arbiter.sv
// div_pipe_arbiter: round-robin scheduler sharing one pipelined divider
// (LATENCY-cycle, one issue per cycle) between NUM_REQ requesters.
// A latency-matched tag pipe steers each result back to its requester, and
// a RUN/DRAIN state machine lets system control quiesce the divider.
// Optional feature macro: DIVARB_DIV0_EN (divide-by-zero detection; the
// response carries all-ones quotient, dividend as remainder, rsp_err=1).
module div_pipe_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DIVISOR_BITS  = 8,
  parameter int DIVIDEND_BITS = 16,
  parameter int REM_BITS      = DIVISOR_BITS + DIVIDEND_BITS - 1,
  parameter int LATENCY       = DIVIDEND_BITS + 2
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*DIVISOR_BITS-1:0]   req_divisor,
  input  logic [NUM_REQ*DIVIDEND_BITS-1:0]  req_dividend,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [DIVISOR_BITS-1:0]           div_divisor,
  output logic [DIVIDEND_BITS-1:0]          div_dividend,
  input  logic [DIVIDEND_BITS-1:0]          div_quotient,
  input  logic [REM_BITS-1:0]               div_remainder,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [DIVIDEND_BITS-1:0]          rsp_quotient,
  output logic [REM_BITS-1:0]               rsp_remainder,
  output logic                              rsp_err,
  input  logic                              drain_req,
  output logic                              drained,
  output logic [4:0]                        inflight
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [ID_W-1:0]            ptr;
  logic [NUM_REQ-1:0]         gnt;
  logic [ID_W-1:0]            gnt_id;
  logic                       issue_en;
  logic                       fire;
  logic                       retire;
  logic [DIVISOR_BITS-1:0]    sel_divisor;
  logic [DIVIDEND_BITS-1:0]   sel_dividend;
  logic [4:0]                 inflight_nxt;
  int                         cand;

  // Tag pipe: stage 0 is loaded on the issue edge, stage LATENCY lines up
  // with the divider output for that op.
  logic [LATENCY:0]           vld_p;
  logic [LATENCY:0][ID_W-1:0] id_p;

`ifdef DIVARB_DIV0_EN
  logic [LATENCY:0]                    err_p;
  logic [LATENCY:0][DIVIDEND_BITS-1:0] dvd_p;

  // Divide-by-zero result substitution: saturate quotient to all ones.
  function automatic logic [DIVIDEND_BITS-1:0] div0_quotient(
    input logic                     err,
    input logic [DIVIDEND_BITS-1:0] q
  );
    return err ? '1 : q;
  endfunction

  // Divide-by-zero result substitution: remainder is the dividend itself.
  function automatic logic [REM_BITS-1:0] div0_remainder(
    input logic                     err,
    input logic [DIVIDEND_BITS-1:0] dvd,
    input logic [REM_BITS-1:0]      r
  );
    return err ? REM_BITS'(dvd) : r;
  endfunction
`endif

  // Round-robin search from ptr upward with wrap; lowest offset wins.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    cand   = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = int'(ptr) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      for (int j = 0; j < NUM_REQ; j++) begin
        if (cand == j && req_valid[j]) begin
          gnt    = '0;
          gnt[j] = 1'b1;
          gnt_id = ID_W'(j);
        end
      end
    end
  end

  // Grant gating: no issue during reset, in DRAIN, or while drain_req is high.
  always_comb begin
    issue_en  = reset_n && (state == RUN) && !drain_req;
    req_ready = issue_en ? gnt : '0;
    fire      = |req_ready;
    retire    = vld_p[LATENCY];
  end

  // Operand mux for the granted requester.
  always_comb begin
    sel_divisor  = '0;
    sel_dividend = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_divisor  = req_divisor[k*DIVISOR_BITS +: DIVISOR_BITS];
        sel_dividend = req_dividend[k*DIVIDEND_BITS +: DIVIDEND_BITS];
      end
    end
  end

  // Next-state and in-flight count for the drain machine.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (drain_req)  state_nxt = DRAIN;
      DRAIN:   if (!drain_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
    case ({fire, retire})
      2'b10:   inflight_nxt = inflight + 5'd1;
      2'b01:   inflight_nxt = inflight - 5'd1;
      default: inflight_nxt = inflight;
    endcase
  end

  // Control state: FSM, pointer, in-flight counter, drained flag, tag valids.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= RUN;
      ptr      <= '0;
      inflight <= '0;
      drained  <= 1'b0;
      vld_p    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= inflight_nxt;
      drained  <= (state_nxt == DRAIN) && (inflight_nxt == 5'd0);
      vld_p    <= {vld_p[LATENCY-1:0], fire};
      if (fire) ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Issue stage: operand registers feeding the divider hold when idle.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      div_divisor  <= '0;
      div_dividend <= '0;
    end else if (fire) begin
      div_divisor  <= sel_divisor;
      div_dividend <= sel_dividend;
    end
  end

  // Tag data stages shift every cycle; only the valid bits need a reset.
  always_ff @(posedge clock) begin
    id_p <= {id_p[LATENCY-1:0], gnt_id};
`ifdef DIVARB_DIV0_EN
    err_p <= {err_p[LATENCY-1:0], (sel_divisor == '0)};
    dvd_p <= {dvd_p[LATENCY-1:0], sel_dividend};
`endif
  end

  // Response stage: capture divider result and the retiring tag.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
`ifdef DIVARB_DIV0_EN
      rsp_err       <= 1'b0;
`endif
    end else begin
      rsp_valid     <= retire ? (NUM_REQ'(1) << id_p[LATENCY]) : '0;
`ifdef DIVARB_DIV0_EN
      rsp_quotient  <= div0_quotient(err_p[LATENCY], div_quotient);
      rsp_remainder <= div0_remainder(err_p[LATENCY], dvd_p[LATENCY], div_remainder);
      rsp_err       <= retire & err_p[LATENCY];
`else
      rsp_quotient  <= div_quotient;
      rsp_remainder <= div_remainder;
`endif
    end
  end

`ifndef DIVARB_DIV0_EN
  assign rsp_err = 1'b0;
`endif

endmodule
